pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequential hazard/flush controller for the 5-stage Y86-64 pipeline. Consumes stage icodes, register IDs,
//  branch outcome and stage status; drives stall/bubble controls for F/D/E/M/W pipeline registers.
//  Tracks in-flight ret with an FSM and counter instead of scanning stage icodes, and drains the pipe on exceptions.
//  Keeps saturating hazard counters for performance debug.
// PARAMETERS
//  CNT_W        32  width of each saturating hazard counter
//  RET_BUBBLES  3   D-stage bubble cycles per ret (ret in D, E, M); legal range 2..7
// PORTS
//  clk         in   1      pipeline clock
//  rst_n       in   1      synchronous active-low reset, sampled on rising clk
//  D_iCode     in   4      icode in decode register
//  E_iCode     in   4      icode in execute register
//  d_srcA      in   4      decode srcA register ID (0xF = none)
//  d_srcB      in   4      decode srcB register ID (0xF = none)
//  E_destM     in   4      execute-stage memory destination register ID (0xF = none)
//  e_Cnd       in   1      execute-stage condition result
//  m_stat      in   4      memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//  W_stat      in   4      writeback-register status
//  F_stall     out  1      hold PC/F register
//  D_stall     out  1      hold D register
//  D_bubble    out  1      load nop into D
//  E_bubble    out  1      load nop into E
//  M_bubble    out  1      load nop into M
//  W_stall     out  1      hold W register
//  set_cc      out  1      CC write enable for OPq in E
//  ctrl_state  out  2      FSM state: 0 RUN, 1 RET, 2 DRAIN, 3 HALTED
//  halted      out  1      1 iff ctrl_state==HALTED
//  luse_cnt    out  CNT_W  load-use stall cycles; mispred_cnt / ret_cnt: same width, mispredict / ret bubble cycles
// BEHAVIOUR
//  Conditions (combinational): luse = E_iCode in {MRMOVQ 5, POPQ B} & E_destM!=0xF & (E_destM==d_srcA | E_destM==d_srcB);
//   mispred = E_iCode==JXX 7 & !e_Cnd; dret = D_iCode==RET 9; mexc = m_stat!=AOK; wexc = W_stat!=AOK.
//  Controls are combinational from state+inputs (same-cycle effect); state, ret counter, hazard counters registered.
//  rst_n low at edge: state->RUN, ret counter->0, all hazard counters->0. While rst_n low, outputs forced:
//   F_stall=0 D_stall=0 D_bubble=1 E_bubble=1 M_bubble=1 W_stall=0 set_cc=0.
//  RUN, priority high->low:
//   wexc: W_stall=1, F_stall=1, D/E/M_bubble=1; next HALTED.
//   mexc: M_bubble=1, F_stall=1, D_bubble=1, E_bubble=1; next DRAIN.
//   mispred: D_bubble=1, E_bubble=1 (ret in D on wrong path is squashed; no RET entry); stay RUN.
//   luse (incl. with dret): F_stall=1, D_stall=1, E_bubble=1; stay RUN (ret re-evaluated next cycle).
//   dret: F_stall=1, D_bubble=1; next RET, counter=RET_BUBBLES-1.
//   else all controls 0.
//  RET: F_stall=1, D_bubble=1, counter decrements; at counter==1 next RUN. wexc/mexc preempt as in RUN.
//  DRAIN: F_stall=1, D/E/M_bubble=1 every cycle; next HALTED on wexc, else stay.
//  HALTED: W_stall=1, F_stall=1, D/E/M_bubble=1; absorbing until reset.
//  Never D_stall & D_bubble together; D_stall only in RUN.
//  set_cc = (E_iCode==OPQ 6) & !mexc & !wexc & state in {RUN, RET}.
//  Counters: luse_cnt +1 per cycle with luse control chosen; mispred_cnt +1 per mispred cycle; ret_cnt +1 per
//   D_bubble cycle due to ret. Saturate at 2^CNT_W-1, never wrap. Reset mid-ret or mid-drain -> RUN, counters 0.
// STRUCTURE
//  Shared package y86_pkg: icode constants (HALT..POPQ), stat constants (AOK/HLT/ADR/INS), RNONE=4'hF,
//   ctrl_state enum {RUN,RET,DRAIN,HALTED}.
//  One sub-module: sat_counter #(W) (clk, rst_n, inc, count), instantiated three times.
// TESTING
//  ret in D at cycle 0, no other hazard -> F_stall=1,D_bubble=1 cycles 0-2, state RUN at cycle 3, ret_cnt=3.
//  E_iCode=5, E_destM=3, d_srcB=3 -> one cycle F_stall=D_stall=E_bubble=1, luse_cnt=1; d_srcA=d_srcB=F, E_destM=F -> no stall.
//  E_iCode=7, e_Cnd=0 with D_iCode=9 -> D_bubble=E_bubble=1, state stays RUN, mispred_cnt=1, ret_cnt=0.
//  m_stat=3 (ADR) while E_iCode=6 -> M_bubble=1, set_cc=0, state DRAIN; next W_stat=3 -> HALTED, W_stall=1 held.
//  rst_n=0 for one edge in RET with counter=1 -> state RUN, counters 0; HALTED then reset -> RUN.
//  Force luse_cnt to 2^CNT_W-1 (CNT_W=4: 15), further luse cycles -> stays 15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants, controller state encoding and the control bundle.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  // Wide enough for RET_BUBBLES up to 7.
  localparam int unsigned RET_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_RET    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stage stall/bubble controls and debug counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [3:0]       D_iCode;
  logic [3:0]       E_iCode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_destM;
  logic             e_Cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic [1:0]       ctrl_state;
  logic             halted;
  logic [CNT_W-1:0] luse_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    output D_iCode, E_iCode, d_srcA, d_srcB, E_destM, e_Cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
    input  ctrl_state, halted, luse_cnt, mispred_cnt, ret_cnt
  );

  modport slave (
    input  D_iCode, E_iCode, d_srcA, d_srcB, E_destM, e_Cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
    output ctrl_state, halted, luse_cnt, mispred_cnt, ret_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 hazard/flush controller: ret tracked by FSM + down-counter, exceptions drain then halt.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RET_BUBBLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam pipe_ctl_t CTL_NONE    = '{default: 1'b0};
  localparam pipe_ctl_t CTL_RST     = '{f_stall: 1'b0, d_stall: 1'b0, d_bubble: 1'b1,
                                        e_bubble: 1'b1, m_bubble: 1'b1, w_stall: 1'b0};
  localparam pipe_ctl_t CTL_HALT    = '{f_stall: 1'b1, d_stall: 1'b0, d_bubble: 1'b1,
                                        e_bubble: 1'b1, m_bubble: 1'b1, w_stall: 1'b1};
  localparam pipe_ctl_t CTL_DRAIN   = '{f_stall: 1'b1, d_stall: 1'b0, d_bubble: 1'b1,
                                        e_bubble: 1'b1, m_bubble: 1'b1, w_stall: 1'b0};
  localparam pipe_ctl_t CTL_MISPRED = '{f_stall: 1'b0, d_stall: 1'b0, d_bubble: 1'b1,
                                        e_bubble: 1'b1, m_bubble: 1'b0, w_stall: 1'b0};
  localparam pipe_ctl_t CTL_LUSE    = '{f_stall: 1'b1, d_stall: 1'b1, d_bubble: 1'b0,
                                        e_bubble: 1'b1, m_bubble: 1'b0, w_stall: 1'b0};
  localparam pipe_ctl_t CTL_RETB    = '{f_stall: 1'b1, d_stall: 1'b0, d_bubble: 1'b1,
                                        e_bubble: 1'b0, m_bubble: 1'b0, w_stall: 1'b0};

  localparam logic [RET_CNT_W-1:0] RET_LOAD = RET_CNT_W'(RET_BUBBLES - 1);

  ctrl_state_e            state_q, state_d;
  logic [RET_CNT_W-1:0]   ret_left_q, ret_left_d;
  pipe_ctl_t              ctl;
  logic                   set_cc_c;
  logic                   luse, mispred, dret, mexc, wexc;
  logic                   luse_inc, mispred_inc, ret_inc;

  // Raw hazard conditions from the current stage contents.
  always_comb begin
    luse    = ((bus.E_iCode == I_MRMOVQ) || (bus.E_iCode == I_POPQ)) &&
              (bus.E_destM != RNONE) &&
              ((bus.E_destM == bus.d_srcA) || (bus.E_destM == bus.d_srcB));
    mispred = (bus.E_iCode == I_JXX) && !bus.e_Cnd;
    dret    = (bus.D_iCode == I_RET);
    mexc    = (bus.m_stat != S_AOK);
    wexc    = (bus.W_stat != S_AOK);
  end

  // Next state, ret countdown, same-cycle pipeline controls and counter events.
  always_comb begin
    state_d     = state_q;
    ret_left_d  = ret_left_q;
    ctl         = CTL_NONE;
    luse_inc    = 1'b0;
    mispred_inc = 1'b0;
    ret_inc     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (wexc) begin
          ctl     = CTL_HALT;
          state_d = ST_HALTED;
        end else if (mexc) begin
          ctl     = CTL_DRAIN;
          state_d = ST_DRAIN;
        end else if (mispred) begin
          // A ret sitting in D here is on the wrong path and gets squashed.
          ctl         = CTL_MISPRED;
          mispred_inc = 1'b1;
        end else if (luse) begin
          // Hold D so a pending ret is re-evaluated once the load clears.
          ctl      = CTL_LUSE;
          luse_inc = 1'b1;
        end else if (dret) begin
          ctl        = CTL_RETB;
          ret_inc    = 1'b1;
          state_d    = ST_RET;
          ret_left_d = RET_LOAD;
        end
      end
      ST_RET: begin
        if (wexc) begin
          ctl     = CTL_HALT;
          state_d = ST_HALTED;
        end else if (mexc) begin
          ctl     = CTL_DRAIN;
          state_d = ST_DRAIN;
        end else begin
          ctl        = CTL_RETB;
          ret_inc    = 1'b1;
          ret_left_d = ret_left_q - RET_CNT_W'(1);
          if (ret_left_q == RET_CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        ctl = CTL_DRAIN;
        if (wexc) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        ctl = CTL_HALT;
      end
    endcase

    set_cc_c = (bus.E_iCode == I_OPQ) && !mexc && !wexc &&
               ((state_q == ST_RUN) || (state_q == ST_RET));

    if (!rst_n) begin
      ctl      = CTL_RST;
      set_cc_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ret_left_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_left_q <= ret_left_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_luse_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (luse_inc),
    .count (bus.luse_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispred_inc),
    .count (bus.mispred_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ret_inc),
    .count (bus.ret_cnt)
  );

  assign bus.F_stall    = ctl.f_stall;
  assign bus.D_stall    = ctl.d_stall;
  assign bus.D_bubble   = ctl.d_bubble;
  assign bus.E_bubble   = ctl.e_bubble;
  assign bus.M_bubble   = ctl.m_bubble;
  assign bus.W_stall    = ctl.w_stall;
  assign bus.set_cc     = set_cc_c;
  assign bus.ctrl_state = state_q;
  assign bus.halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expectations queued at drive time, popped and asserted after settle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b0011100;
  localparam logic [6:0] C_RET   = 7'b1010000;
  localparam logic [6:0] C_LUSE  = 7'b1101000;
  localparam logic [6:0] C_MISP  = 7'b0011000;
  localparam logic [6:0] C_DRAIN = 7'b1011100;
  localparam logic [6:0] C_HALT  = 7'b1011110;
  localparam logic [6:0] C_CC    = 7'b0000001;

  localparam int K_CTL = 0, K_ST = 1, K_HALTED = 2, K_LUSE = 3, K_MISP = 4, K_RETC = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;
  exp_t sb[$];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .RET_BUBBLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int k);
    case (k)
      K_CTL:    return 32'({bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                            bus.M_bubble, bus.W_stall, bus.set_cc});
      K_ST:     return 32'(bus.ctrl_state);
      K_HALTED: return 32'(bus.halted);
      K_LUSE:   return 32'(bus.luse_cnt);
      K_MISP:   return 32'(bus.mispred_cnt);
      default:  return 32'(bus.ret_cnt);
    endcase
  endfunction

  task automatic push(string tag, int kind, logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_cycle(string tag, logic [6:0] c, logic [1:0] st);
    push({tag, ".ctl"}, K_CTL, 32'(c));
    push({tag, ".state"}, K_ST, 32'(st));
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] got;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.kind);
      total_cnt++;
      assert (got === e.exp) begin
        pass_cnt++;
      end else begin
        fail_cnt++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, got, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.D_iCode = 4'h1;
    bus.E_iCode = 4'h1;
    bus.d_srcA  = 4'hF;
    bus.d_srcB  = 4'hF;
    bus.E_destM = 4'hF;
    bus.e_Cnd   = 1'b0;
    bus.m_stat  = 4'h1;
    bus.W_stat  = 4'h1;
  endtask

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    idle();

    // Reset: forced controls, then cleared state and counters.
    expect_cycle("rst_force", C_RST, 2'd0);
    check_all();
    tick();
    push("rst_halted", K_HALTED, 32'd0);
    push("rst_luse", K_LUSE, 32'd0);
    push("rst_misp", K_MISP, 32'd0);
    push("rst_retc", K_RETC, 32'd0);
    check_all();
    rst_n = 1'b1;
    expect_cycle("idle", C_NONE, 2'd0);
    check_all();
    tick();

    // ret in D: three D bubbles, back to RUN on the fourth cycle.
    bus.D_iCode = 4'h9;
    expect_cycle("ret0", C_RET, 2'd0);
    check_all();
    tick();
    bus.D_iCode = 4'h1;
    expect_cycle("ret1", C_RET, 2'd1);
    check_all();
    tick();
    expect_cycle("ret2", C_RET, 2'd1);
    check_all();
    tick();
    expect_cycle("ret3", C_NONE, 2'd0);
    push("ret_cnt3", K_RETC, 32'd3);
    check_all();

    // Load-use on srcB.
    bus.E_iCode = 4'h5;
    bus.E_destM = 4'h3;
    bus.d_srcB  = 4'h3;
    expect_cycle("luse", C_LUSE, 2'd0);
    check_all();
    tick();
    bus.d_srcB  = 4'hF;
    bus.E_destM = 4'hF;
    expect_cycle("luse_none", C_NONE, 2'd0);
    push("luse_cnt1", K_LUSE, 32'd1);
    check_all();
    tick();

    // Mispredict squashes a ret in D.
    bus.E_iCode = 4'h7;
    bus.D_iCode = 4'h9;
    expect_cycle("misp", C_MISP, 2'd0);
    check_all();
    tick();
    bus.D_iCode = 4'h1;
    bus.e_Cnd   = 1'b1;
    expect_cycle("jxx_taken", C_NONE, 2'd0);
    push("misp_cnt1", K_MISP, 32'd1);
    push("misp_retc", K_RETC, 32'd3);
    check_all();
    tick();

    // Load-use wins over ret; ret proceeds once the load clears.
    bus.e_Cnd   = 1'b0;
    bus.E_iCode = 4'hB;
    bus.E_destM = 4'h2;
    bus.d_srcA  = 4'h2;
    bus.D_iCode = 4'h9;
    expect_cycle("luse_ret", C_LUSE, 2'd0);
    check_all();
    tick();
    bus.E_iCode = 4'h1;
    bus.E_destM = 4'hF;
    bus.d_srcA  = 4'hF;
    expect_cycle("ret_after_luse", C_RET, 2'd0);
    check_all();
    tick();
    bus.D_iCode = 4'h1;
    bus.E_iCode = 4'h6;
    push("ret_setcc", K_CTL, 32'({C_RET[6:1], 1'b1}));
    check_all();
    tick();
    expect_cycle("ret_b2", {C_RET[6:1], 1'b1}, 2'd1);
    check_all();
    tick();
    expect_cycle("opq_run", C_CC, 2'd0);
    push("retc6", K_RETC, 32'd6);
    push("luse2", K_LUSE, 32'd2);
    check_all();

    // Memory exception drains, writeback exception halts.
    bus.m_stat = 4'h3;
    expect_cycle("mexc", C_DRAIN, 2'd0);
    check_all();
    tick();
    bus.m_stat = 4'h1;
    expect_cycle("drain", C_DRAIN, 2'd2);
    check_all();
    tick();
    bus.W_stat = 4'h3;
    expect_cycle("drain_wexc", C_DRAIN, 2'd2);
    check_all();
    tick();
    bus.W_stat = 4'h1;
    expect_cycle("halted", C_HALT, 2'd3);
    push("halted_flag", K_HALTED, 32'd1);
    check_all();
    tick();
    expect_cycle("halted_hold", C_HALT, 2'd3);
    check_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    expect_cycle("halt_rst", C_NONE, 2'd0);
    push("halt_rst_retc", K_RETC, 32'd0);
    push("halt_rst_luse", K_LUSE, 32'd0);
    check_all();

    // Reset mid-ret with countdown at 1.
    bus.D_iCode = 4'h9;
    tick();
    bus.D_iCode = 4'h1;
    tick();
    expect_cycle("ret_last", C_RET, 2'd1);
    check_all();
    rst_n = 1'b0;
    push("ret_rst_force", K_CTL, 32'(C_RST));
    check_all();
    tick();
    rst_n = 1'b1;
    expect_cycle("ret_rst", C_NONE, 2'd0);
    push("ret_rst_retc", K_RETC, 32'd0);
    check_all();

    // Exceptions preempt an in-flight ret; wexc in RUN halts directly.
    bus.D_iCode = 4'h9;
    tick();
    bus.D_iCode = 4'h1;
    bus.m_stat  = 4'h4;
    expect_cycle("ret_mexc", C_DRAIN, 2'd1);
    check_all();
    tick();
    bus.m_stat = 4'h1;
    expect_cycle("ret_mexc_drain", C_DRAIN, 2'd2);
    check_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.W_stat = 4'h2;
    expect_cycle("run_wexc", C_HALT, 2'd0);
    check_all();
    tick();
    bus.W_stat = 4'h1;
    expect_cycle("run_wexc_halt", C_HALT, 2'd3);
    check_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Saturation of the load-use counter.
    bus.E_iCode = 4'h5;
    bus.E_destM = 4'h4;
    bus.d_srcA  = 4'h4;
    for (int i = 0; i < 17; i++) begin
      push("sat_luse_ctl", K_CTL, 32'(C_LUSE));
      check_all();
      tick();
    end
    push("sat15", K_LUSE, 32'd15);
    check_all();
    tick();
    push("sat15_hold", K_LUSE, 32'd15);
    check_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
